// File: rtl/jt12_wr_queue.sv
// Purpose: queue (part, reg, val) writes and replay each as an address write then a data write on the jt12 CPU bus.
// Latency: a request accepted at edge 0 into an empty queue (chip not busy) drops wr_n at edge 3, and it rises at edge 3+WR_W.
// Backpressure: in_ready = !full; it is not reopened by a pop in the same cycle, and a push on a flush edge is dropped.
//
// Ports:
//   clk, rst                    system clock, asynchronous active-high reset
//   in_valid/in_ready           request handshake; in_part/in_reg/in_val form the request
//   flush                       drop every queued entry (the in-flight pair still completes)
//   level, idle, timeout        occupancy, queue-empty-and-FSM-idle, sticky busy-wait expiry
//   ym_busy                     chip busy flag (asynchronous to clk)
//   ym_addr/ym_din/ym_cs_n/ym_wr_n  chip CPU bus
module jt12_wr_queue #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int WR_W    = 2,
    parameter int GAP     = 4,
    parameter int BUSY_TO = 1000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_part,
    input  logic [7:0]    in_reg,
    input  logic [7:0]    in_val,
    input  logic          flush,
    output logic [AW:0]   level,
    output logic          idle,
    output logic          timeout,
    input  logic          ym_busy,
    output logic [1:0]    ym_addr,
    output logic [7:0]    ym_din,
    output logic          ym_cs_n,
    output logic          ym_wr_n
);

    typedef struct packed {
        logic       part;
        logic [7:0] rg;
        logic [7:0] val;
    } req_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_GAP
    } state_t;

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    req_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;

    state_t        state;
    req_t          work;
    logic          phase;
    logic [15:0]   to_cnt;
    logic [15:0]   tm_cnt;
    logic          busy_m;
    logic          busy_s;

    logic          push;
    logic          pop;
    logic          empty;

    assign empty    = (cnt == '0);
    assign in_ready = (cnt != FULL_LVL);
    assign level    = cnt;
    // Both terms are registers, so idle changes only on the edge that moves the state or level.
    assign idle     = empty && (state == S_IDLE);

    // A flush edge neither accepts nor pops; the FSM simply stays in IDLE that cycle.
    assign push = in_valid && in_ready && !flush;
    assign pop  = (state == S_IDLE) && !empty && !flush;

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{part: in_part, rg: in_reg, val: in_val};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
        end
    end

    // Two-flop synchroniser for the chip busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_m <= 1'b0;
            busy_s <= 1'b0;
        end else begin
            busy_m <= ym_busy;
            busy_s <= busy_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            work    <= '0;
            phase   <= 1'b0;
            to_cnt  <= '0;
            tm_cnt  <= '0;
            timeout <= 1'b0;
            ym_addr <= '0;
            ym_din  <= '0;
            ym_cs_n <= 1'b1;
            ym_wr_n <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        work  <= mem[rd_ptr];
                        phase <= 1'b0;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Leaving WAIT presents the bus address/data for the SETUP cycle.
                    if (!busy_s || (to_cnt == 16'(BUSY_TO - 1))) begin
                        if (busy_s) timeout <= 1'b1;
                        to_cnt  <= '0;
                        ym_addr <= {work.part, phase};
                        ym_din  <= phase ? work.val : work.rg;
                        state   <= S_SETUP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_SETUP: begin
                    ym_cs_n <= 1'b0;
                    ym_wr_n <= 1'b0;
                    tm_cnt  <= '0;
                    state   <= S_STROBE;
                end
                S_STROBE: begin
                    if (tm_cnt == 16'(WR_W - 1)) begin
                        ym_cs_n <= 1'b1;
                        ym_wr_n <= 1'b1;
                        tm_cnt  <= '0;
                        state   <= S_HOLD;
                    end else begin
                        tm_cnt <= tm_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    tm_cnt <= '0;
                    state  <= S_GAP;
                end
                S_GAP: begin
                    if (tm_cnt == 16'(GAP - 1)) begin
                        tm_cnt <= '0;
                        if (!phase) begin
                            phase <= 1'b1;
                            state <= S_WAIT;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        tm_cnt <= tm_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jt12_wr_queue.sv
module tb_jt12_wr_queue;

    localparam int DEPTH   = 16;
    localparam int AW      = 4;
    localparam int WR_W    = 2;
    localparam int GAP     = 4;
    localparam int BUSY_TO = 60;
    // Edges from one bus-write strobe start to the next within a pair.
    localparam int WSTEP   = WR_W + 1 + GAP + 2;
    // Edges between address strobes of back-to-back pairs.
    localparam int PSTEP   = 2 * WSTEP + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_part = 1'b0;
    logic [7:0]    in_reg = '0;
    logic [7:0]    in_val = '0;
    logic          flush = 1'b0;
    logic [AW:0]   level;
    logic          idle;
    logic          timeout;
    logic          ym_busy = 1'b0;
    logic [1:0]    ym_addr;
    logic [7:0]    ym_din;
    logic          ym_cs_n;
    logic          ym_wr_n;

    jt12_wr_queue #(
        .DEPTH(DEPTH), .AW(AW), .WR_W(WR_W), .GAP(GAP), .BUSY_TO(BUSY_TO)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_part(in_part), .in_reg(in_reg), .in_val(in_val),
        .flush(flush), .level(level), .idle(idle), .timeout(timeout),
        .ym_busy(ym_busy), .ym_addr(ym_addr), .ym_din(ym_din),
        .ym_cs_n(ym_cs_n), .ym_wr_n(ym_wr_n)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc++;

    // Reference model: every accepted request becomes two expected bus writes.
    typedef struct {
        logic [1:0] addr;
        logic [7:0] din;
        int         pair;
    } wr_t;

    wr_t expq[$];
    int  fall_cyc[$];
    int  pair_id  = 0;
    int  cur_pair = -1;
    bit  mon_en   = 1'b1;

    logic       prev_wr = 1'b1;
    int         lowcnt  = 0;
    logic [1:0] s_addr;
    logic [7:0] s_din;

    // Bus monitor: checks each write against the model and its strobe shape.
    always @(negedge clk) begin
        wr_t e;
        if (!mon_en || rst) begin
            prev_wr = 1'b1;
            lowcnt  = 0;
        end else begin
            if (prev_wr && !ym_wr_n) begin
                fall_cyc.push_back(cyc);
                vectors++;
                assert (expq.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_write observed addr=%0d din=%02h expected no write", ym_addr, ym_din);
                end
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    cur_pair = e.pair;
                    vectors++;
                    assert ({ym_addr, ym_din} === {e.addr, e.din}) else begin
                        errors++;
                        $error("FAIL bus_write observed addr=%0d din=%02h expected addr=%0d din=%02h",
                               ym_addr, ym_din, e.addr, e.din);
                    end
                end
                vectors++;
                assert (ym_cs_n === 1'b0) else begin
                    errors++;
                    $error("FAIL cs_n_low observed=%b expected=0", ym_cs_n);
                end
                s_addr = ym_addr;
                s_din  = ym_din;
                lowcnt = 1;
            end else if (!ym_wr_n) begin
                lowcnt++;
                vectors++;
                assert ({ym_addr, ym_din} === {s_addr, s_din}) else begin
                    errors++;
                    $error("FAIL bus_stable observed addr=%0d din=%02h expected addr=%0d din=%02h",
                           ym_addr, ym_din, s_addr, s_din);
                end
            end else if (!prev_wr && ym_wr_n) begin
                vectors++;
                assert (lowcnt == WR_W) else begin
                    errors++;
                    $error("FAIL strobe_width observed=%0d expected=%0d", lowcnt, WR_W);
                end
                vectors++;
                assert (ym_cs_n === 1'b1) else begin
                    errors++;
                    $error("FAIL cs_n_high observed=%b expected=1", ym_cs_n);
                end
            end
            prev_wr = ym_wr_n;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic p, input logic [7:0] r, input logic [7:0] v,
                        input bit exp_acc, output int edge_no);
        in_valid = 1'b1;
        in_part  = p;
        in_reg   = r;
        in_val   = v;
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_acc});
        if (exp_acc) begin
            expq.push_back('{addr: {p, 1'b0}, din: r, pair: pair_id});
            expq.push_back('{addr: {p, 1'b1}, din: v, pair: pair_id});
            pair_id++;
        end
        @(posedge clk); #1;
        edge_no  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max, output int at);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (idle !== 1'b1 && n < max) begin
            @(posedge clk); #1;
            n++;
        end
        at = cyc;
        chk("idle_reached", {31'b0, idle}, 32'd1);
    endtask

    task automatic wait_wr_low(input int max, input string tag);
        int n;
        n = 0;
        while (ym_wr_n !== 1'b0 && n < max) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, {31'b0, ym_wr_n}, 32'd0);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  e0, at, base, bfall, dummy;
        logic       p;
        logic [7:0] r, v;
        wr_t keep[$];

        // Reset state
        cycles(3);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_level",    {27'b0, level},    32'd0);
        chk("rst_idle",     {31'b0, idle},     32'd1);
        chk("rst_timeout",  {31'b0, timeout},  32'd0);
        chk("rst_addr",     {30'b0, ym_addr},  32'd0);
        chk("rst_din",      {24'b0, ym_din},   32'd0);
        chk("rst_cs_n",     {31'b0, ym_cs_n},  32'd1);
        chk("rst_wr_n",     {31'b0, ym_wr_n},  32'd1);
        rst = 1'b0;
        cycles(2);

        // 1: single write, exact edge timing
        fall_cyc.delete();
        push(1'b0, 8'h28, 8'hF0, 1'b1, e0);
        chk("t1_idle_busy", {31'b0, idle}, 32'd0);
        wait_idle(60, at);
        chk("t1_nwrites",  fall_cyc.size(), 32'd2);
        chk("t1_addr_edge", fall_cyc[0], e0 + 3);
        chk("t1_data_edge", fall_cyc[1], e0 + 3 + WSTEP);
        chk("t1_idle_edge", at, e0 + 3 + WSTEP + WR_W + 1 + GAP);
        chk("t1_timeout",  {31'b0, timeout}, 32'd0);
        chk("t1_last_addr", {30'b0, ym_addr}, 32'd1);
        chk("t1_last_din",  {24'b0, ym_din}, 32'hF0);

        // 2: part II, then random single requests
        push(1'b1, 8'hB4, 8'hC0, 1'b1, e0);
        wait_idle(60, at);
        chk("t2_last_addr", {30'b0, ym_addr}, 32'd3);
        for (int k = 0; k < 4; k++) begin
            p = 1'($urandom_range(0, 1));
            r = 8'($urandom);
            v = 8'($urandom);
            push(p, r, v, 1'b1, e0);
            wait_idle(60, at);
            chk("t2_rand_addr", {30'b0, ym_addr}, {30'b0, p, 1'b1});
            chk("t2_rand_din",  {24'b0, ym_din}, {24'b0, v});
        end

        // Back-to-back: pop on the edge after GAP ends
        fall_cyc.delete();
        push(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'b1, base);
        for (int k = 1; k < 3; k++)
            push(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'b1, dummy);
        wait_idle(200, at);
        chk("b2b_nwrites", fall_cyc.size(), 32'd6);
        for (int k = 0; k < 3; k++) begin
            chk("b2b_addr_edge", fall_cyc[2*k],   base + 3 + PSTEP*k);
            chk("b2b_data_edge", fall_cyc[2*k+1], base + 3 + WSTEP + PSTEP*k);
        end

        // 3a: busy held for 50 cycles after the address strobe
        fall_cyc.delete();
        push(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'b1, e0);
        wait_wr_low(20, "t3_addr_strobe");
        ym_busy = 1'b1;
        cycles(50);
        bfall = cyc;
        ym_busy = 1'b0;
        wait_idle(100, at);
        chk("t3_nwrites",   fall_cyc.size(), 32'd2);
        chk("t3_data_edge", fall_cyc[1], bfall + 4);
        chk("t3_timeout",   {31'b0, timeout}, 32'd0);

        // 4: fill while busy
        ym_busy = 1'b1;
        cycles(3);
        for (int k = 0; k < DEPTH + 1; k++)
            push(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'b1, dummy);
        chk("t4_level_full", {27'b0, level}, DEPTH);
        push(1'b1, 8'hEE, 8'hEE, 1'b0, dummy);
        chk("t4_level_hold", {27'b0, level}, DEPTH);
        chk("t4_idle",       {31'b0, idle}, 32'd0);
        ym_busy = 1'b0;
        wait_idle(800, at);
        chk("t4_drained", expq.size(), 32'd0);
        chk("t4_timeout", {31'b0, timeout}, 32'd0);

        // 5: flush mid-stream; a push on the flush edge is dropped
        fall_cyc.delete();
        for (int k = 0; k < 5; k++)
            push(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'b1, dummy);
        wait_wr_low(20, "t5_first_strobe");
        flush    = 1'b1;
        in_valid = 1'b1;
        in_part  = 1'b1;
        in_reg   = 8'h55;
        in_val   = 8'hAA;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        keep.delete();
        foreach (expq[i]) if (expq[i].pair == cur_pair) keep.push_back(expq[i]);
        expq = keep;
        chk("t5_level", {27'b0, level}, 32'd0);
        wait_idle(60, at);
        cycles(30);
        chk("t5_nwrites", fall_cyc.size(), 32'd2);
        chk("t5_idle",    {31'b0, idle}, 32'd1);
        chk("t5_pending", expq.size(), 32'd0);

        // 6: asynchronous reset during STROBE
        fall_cyc.delete();
        push(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'b1, dummy);
        push(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'b1, dummy);
        wait_wr_low(20, "t6_strobe");
        mon_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t6_cs_n_async", {31'b0, ym_cs_n}, 32'd1);
        chk("t6_wr_n_async", {31'b0, ym_wr_n}, 32'd1);
        cycles(2);
        rst = 1'b0;
        expq.delete();
        fall_cyc.delete();
        mon_en = 1'b1;
        cycles(50);
        chk("t6_level",   {27'b0, level}, 32'd0);
        chk("t6_idle",    {31'b0, idle}, 32'd1);
        chk("t6_replay",  fall_cyc.size(), 32'd0);

        // 3b: busy stuck high -> timeout, both writes still issue
        ym_busy = 1'b1;
        cycles(3);
        push(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'b1, e0);
        cycles(BUSY_TO / 2);
        chk("t3b_timeout_early", {31'b0, timeout}, 32'd0);
        wait_idle(4 * BUSY_TO, at);
        chk("t3b_timeout", {31'b0, timeout}, 32'd1);
        chk("t3b_nwrites", fall_cyc.size(), 32'd2);
        ym_busy = 1'b0;
        cycles(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
